// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multicycle RV32I control path: FSM states, op classes, mux encodings, opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_LOAD   = 4'd1,
        CLS_STORE  = 4'd2,
        CLS_BRANCH = 4'd3,
        CLS_OPIMM  = 4'd4,
        CLS_OP     = 4'd5,
        CLS_LUI    = 4'd6,
        CLS_AUIPC  = 4'd7,
        CLS_JAL    = 4'd8,
        CLS_JALR   = 4'd9
    } op_class_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_TARGET = 2'd1,
        PC_JALR   = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Register-register ALU ops and branch compares take rs2 as operand B; everything else uses the immediate.
    function automatic logic alu_b_uses_imm(input op_class_e c);
        return !((c == CLS_OP) || (c == CLS_BRANCH));
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Opcode classifier: maps instr[6:0] to an op class, a legal flag and the immediate format.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input every cycle.
module op_class_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output op_class_e  o_class,
    output logic       o_legal,
    output imm_sel_e   o_imm_sel
);

    // Table lookup on the major opcode; unknown opcodes are reported illegal with no immediate.
    always_comb begin
        o_class   = CLS_NONE;
        o_legal   = 1'b1;
        o_imm_sel = IMM_NONE;
        case (i_opcode)
            OPC_LOAD:   begin o_class = CLS_LOAD;   o_imm_sel = IMM_I; end
            OPC_STORE:  begin o_class = CLS_STORE;  o_imm_sel = IMM_S; end
            OPC_BRANCH: begin o_class = CLS_BRANCH; o_imm_sel = IMM_B; end
            OPC_OPIMM:  begin o_class = CLS_OPIMM;  o_imm_sel = IMM_I; end
            OPC_OP:     begin o_class = CLS_OP;     o_imm_sel = IMM_NONE; end
            OPC_LUI:    begin o_class = CLS_LUI;    o_imm_sel = IMM_U; end
            OPC_AUIPC:  begin o_class = CLS_AUIPC;  o_imm_sel = IMM_U; end
            OPC_JAL:    begin o_class = CLS_JAL;    o_imm_sel = IMM_J; end
            OPC_JALR:   begin o_class = CLS_JALR;   o_imm_sel = IMM_I; end
            default:    begin o_legal = 1'b0; end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP on illegal opcodes.
// Latency FETCH->FETCH at zero wait: branch 3, ALU/LUI/AUIPC/JAL/JALR/store 4, load 5 cycles.
// Backpressure: FETCH and MEM hold their request until the matching ready is sampled high.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  imm_sel,
    output logic        alu_b_sel,
    output logic [1:0]  wb_sel,
    output logic        trap
);

    state_e    r_state;
    op_class_e r_class;
    logic      r_trap;

    op_class_e w_class;
    logic      w_legal;
    imm_sel_e  w_imm_sel;

    // Width only keeps the parameter list uniform with the datapath; upper instr bits are the datapath's business.
    logic [Width-1:0] w_unused_width;
    logic             w_unused_instr;
    assign w_unused_width = '0;
    assign w_unused_instr = ^instr[31:7];

    op_class_decode u_decode (
        .i_opcode  (instr[6:0]),
        .o_class   (w_class),
        .o_legal   (w_legal),
        .o_imm_sel (w_imm_sel)
    );

    // State sequencing; the class is latched once in DECODE and steers every later state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_class <= CLS_NONE;
            r_trap  <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ready) r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_legal) begin
                        r_class <= w_class;
                        r_state <= ST_EXEC;
                    end else begin
                        r_class <= CLS_NONE;
                        r_trap  <= 1'b1;
                        r_state <= ST_TRAP;
                    end
                end
                ST_EXEC: begin
                    if (r_class == CLS_BRANCH) begin
                        r_state <= ST_FETCH;
                    end else if ((r_class == CLS_LOAD) || (r_class == CLS_STORE)) begin
                        r_state <= ST_MEM;
                    end else begin
                        r_state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) r_state <= (r_class == CLS_LOAD) ? ST_WB : ST_FETCH;
                end
                ST_WB: begin
                    r_state <= ST_FETCH;
                end
                ST_TRAP: begin
                    r_state <= ST_TRAP;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    // Moore decode of state and latched class; only ir_we and the store pc_we look at a ready input.
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        pc_sel    = PC_PLUS4;
        alu_b_sel = 1'b0;
        wb_sel    = WB_ALU;
        case (r_state)
            ST_FETCH: begin
                // rst_n gating drops the fetch request the instant reset asserts.
                imem_req = rst_n;
                ir_we    = rst_n & imem_ready;
            end
            ST_EXEC: begin
                alu_b_sel = alu_b_uses_imm(r_class);
                if (r_class == CLS_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? PC_TARGET : PC_PLUS4;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (r_class == CLS_STORE);
                pc_we    = (r_class == CLS_STORE) & dmem_ready;
            end
            ST_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                case (r_class)
                    CLS_LOAD: wb_sel = WB_LOAD;
                    CLS_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_TARGET; end
                    CLS_JALR: begin wb_sel = WB_PC4; pc_sel = PC_JALR;   end
                    default:  ;
                endcase
            end
            default: ;
        endcase
    end

    // Immediate format tracks the live opcode from DECODE through WB; FETCH and TRAP never request one.
    always_comb begin
        imm_sel = IMM_NONE;
        if ((r_state == ST_DECODE) || (r_state == ST_EXEC) ||
            (r_state == ST_MEM)    || (r_state == ST_WB)) begin
            imm_sel = w_imm_sel;
        end
    end

    assign trap = r_trap;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed table, reset/trap sequences, randomized instruction stream.
// Latency: n/a (testbench).
// Backpressure: ready inputs are stalled randomly and toggled while their request is low.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        branch_taken;
    logic        imem_req, imem_ready;
    logic        dmem_req, dmem_we, dmem_ready;
    logic        ir_we, pc_we, reg_we;
    logic [1:0]  pc_sel;
    logic [2:0]  imm_sel;
    logic        alu_b_sel;
    logic [1:0]  wb_sel;
    logic        trap;

    int n_vec  = 0;
    int n_miss = 0;

    multicycle_ctrl #(.Width(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .branch_taken(branch_taken),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
        .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_b_sel(alu_b_sel),
        .wb_sel(wb_sel), .trap(trap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_we;
        logic       reg_we;
        logic [1:0] pc_sel;
        logic [2:0] imm_sel;
        logic       alu_b_sel;
        logic [1:0] wb_sel;
        logic       trap;
    } out_t;

    localparam int K_BAD = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3, K_OPIMM = 4,
                   K_OP = 5, K_LUI = 6, K_AUIPC = 7, K_JAL = 8, K_JALR = 9;

    function automatic out_t get_out();
        out_t o;
        o.imem_req  = imem_req;
        o.ir_we     = ir_we;
        o.dmem_req  = dmem_req;
        o.dmem_we   = dmem_we;
        o.pc_we     = pc_we;
        o.reg_we    = reg_we;
        o.pc_sel    = pc_sel;
        o.imm_sel   = imm_sel;
        o.alu_b_sel = alu_b_sel;
        o.wb_sel    = wb_sel;
        o.trap      = trap;
        return o;
    endfunction

    // RV32I major opcode -> instruction kind and immediate format code
    function automatic void classify(input logic [6:0] op, output int k, output logic [2:0] im);
        k  = K_BAD;
        im = 3'd0;
        case (op)
            7'b0000011: begin k = K_LOAD;   im = 3'd1; end
            7'b0100011: begin k = K_STORE;  im = 3'd2; end
            7'b1100011: begin k = K_BRANCH; im = 3'd3; end
            7'b0010011: begin k = K_OPIMM;  im = 3'd1; end
            7'b0110011: begin k = K_OP;     im = 3'd0; end
            7'b0110111: begin k = K_LUI;    im = 3'd4; end
            7'b0010111: begin k = K_AUIPC;  im = 3'd4; end
            7'b1101111: begin k = K_JAL;    im = 3'd5; end
            7'b1100111: begin k = K_JALR;   im = 3'd1; end
            default:    ;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic chk_out(input string nm, input out_t act, input out_t expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Reset with all readies high, check outputs quiet, release and check fetch request rises at once.
    task automatic do_reset(input string nm);
        out_t e;
        @(negedge clk);
        rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b1;
        #1 chk_out({nm, "_in_reset"}, get_out(), '0);
        @(negedge clk);
        #1 chk_out({nm, "_held_reset"}, get_out(), '0);
        imem_ready = 1'b0; dmem_ready = 1'b0; rst_n = 1'b1;
        #1;
        e = '0; e.imem_req = 1'b1;
        chk_out({nm, "_release"}, get_out(), e);
    endtask

    // Builds the expected per-cycle output trace of one instruction from its phase list, then drives and compares it.
    task automatic run_instr(input string name, input logic [31:0] ins, input logic bt,
                             input int iw, input int dw, input bit noise,
                             output int lat, output int n_reg, output int n_pcwe, output int n_dreq,
                             output int pcsel_we, output int wbsel_we, output int imm_dec);
        out_t q[$];
        bit   imr[$];
        bit   dmr[$];
        bit   ex[$];
        out_t e, a;
        int   k;
        logic [2:0] im;
        bit   ld, st, br;
        classify(ins[6:0], k, im);
        ld = (k == K_LOAD); st = (k == K_STORE); br = (k == K_BRANCH);
        for (int c = 0; c <= iw; c++) begin
            e = '0; e.imem_req = 1'b1; e.ir_we = (c == iw);
            q.push_back(e); imr.push_back(c == iw); dmr.push_back(1'b0); ex.push_back(1'b0);
        end
        e = '0; e.imm_sel = im;
        q.push_back(e); imr.push_back(1'b0); dmr.push_back(1'b0); ex.push_back(1'b0);
        e = '0; e.imm_sel = im; e.alu_b_sel = !((k == K_OP) || br);
        if (br) begin e.pc_we = 1'b1; e.pc_sel = {1'b0, bt}; end
        q.push_back(e); imr.push_back(1'b0); dmr.push_back(1'b0); ex.push_back(1'b1);
        if (ld || st) begin
            for (int c = 0; c <= dw; c++) begin
                e = '0; e.imm_sel = im; e.dmem_req = 1'b1; e.dmem_we = st; e.pc_we = st && (c == dw);
                q.push_back(e); imr.push_back(1'b0); dmr.push_back(c == dw); ex.push_back(1'b0);
            end
        end
        if (!br && !st) begin
            e = '0; e.imm_sel = im; e.reg_we = 1'b1; e.pc_we = 1'b1;
            if (ld) e.wb_sel = 2'd1;
            if (k == K_JAL)  begin e.wb_sel = 2'd2; e.pc_sel = 2'd1; end
            if (k == K_JALR) begin e.wb_sel = 2'd2; e.pc_sel = 2'd2; end
            q.push_back(e); imr.push_back(1'b0); dmr.push_back(1'b0); ex.push_back(1'b0);
        end

        lat = -1; n_reg = 0; n_pcwe = 0; n_dreq = 0; pcsel_we = 0; wbsel_we = 0; imm_dec = -1;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            imem_ready   = q[i].imem_req ? imr[i] : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            dmem_ready   = q[i].dmem_req ? dmr[i] : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            branch_taken = ex[i] ? bt : 1'($urandom_range(0, 1));
            instr        = (i <= iw) ? $urandom : ins;
            #1;
            a = get_out();
            n_vec++;
            if (a !== q[i]) begin
                n_miss++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, i, a, q[i]);
            end
            if ((i > iw) && a.imem_req && (lat < 0)) lat = i;
            if (a.reg_we) begin n_reg++; wbsel_we = int'(a.wb_sel); end
            if (a.pc_we) begin n_pcwe++; pcsel_we = int'(a.pc_sel); end
            if (a.dmem_req) n_dreq++;
            if (i == iw + 1) imm_dec = int'(a.imm_sel);
        end
        @(negedge clk);
        imem_ready = 1'b0; dmem_ready = 1'b0;
        #1;
        if (get_out().imem_req && (lat < 0)) lat = q.size();
    endtask

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic        bt;
        int          lat;
        int          nreg;
        int          pcsel;
        int          wbsel;
        int          imm;
    } vec_t;

    vec_t tbl[10];
    logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0110011,
                            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

    initial begin
        int lat, nreg, npcwe, ndreq, pcs, wbs, imd;
        out_t e;
        logic [31:0] r;

        tbl[0] = '{"addi",   32'h00500093, 1'b0, 4, 1, 0, 0, 1};
        tbl[1] = '{"add",    32'h002081B3, 1'b0, 4, 1, 0, 0, 0};
        tbl[2] = '{"lui",    32'h123450B7, 1'b0, 4, 1, 0, 0, 4};
        tbl[3] = '{"auipc",  32'h00001097, 1'b0, 4, 1, 0, 0, 4};
        tbl[4] = '{"jal",    32'h008000EF, 1'b0, 4, 1, 1, 2, 5};
        tbl[5] = '{"jalr",   32'h000080E7, 1'b0, 4, 1, 2, 2, 1};
        tbl[6] = '{"sw",     32'h00112023, 1'b0, 4, 0, 0, 0, 2};
        tbl[7] = '{"lw",     32'h0000A103, 1'b0, 5, 1, 0, 1, 1};
        tbl[8] = '{"beq_t",  32'h00000463, 1'b1, 3, 0, 1, 0, 3};
        tbl[9] = '{"beq_nt", 32'h00000463, 1'b0, 3, 0, 0, 0, 3};

        rst_n = 1'b0; instr = '0; branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        do_reset("por");

        // Directed table at zero wait states
        for (int t = 0; t < 10; t++) begin
            run_instr(tbl[t].name, tbl[t].ins, tbl[t].bt, 0, 0, 1'b0,
                      lat, nreg, npcwe, ndreq, pcs, wbs, imd);
            chk({tbl[t].name, "_latency"}, lat, tbl[t].lat);
            chk({tbl[t].name, "_reg_we_count"}, nreg, tbl[t].nreg);
            chk({tbl[t].name, "_pc_we_count"}, npcwe, 1);
            chk({tbl[t].name, "_pc_sel"}, pcs, tbl[t].pcsel);
            chk({tbl[t].name, "_wb_sel"}, wbs, tbl[t].wbsel);
            chk({tbl[t].name, "_imm_sel"}, imd, tbl[t].imm);
        end

        // LW with data ready delayed three cycles
        run_instr("lw_wait3", 32'h0000A103, 1'b0, 0, 3, 1'b0, lat, nreg, npcwe, ndreq, pcs, wbs, imd);
        chk("lw_wait3_dmem_req_cycles", ndreq, 4);
        chk("lw_wait3_total", lat, 8);
        chk("lw_wait3_wb_sel", wbs, 1);

        // Illegal opcode: trap from the cycle after DECODE, absorbing, cleared by reset
        @(negedge clk);
        imem_ready = 1'b1; instr = $urandom;
        #1 e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1;
        chk_out("illegal_fetch", get_out(), e);
        @(negedge clk);
        imem_ready = 1'b0; instr = 32'hFFFFFFFF;
        #1 chk_out("illegal_decode", get_out(), '0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            imem_ready = 1'($urandom_range(0, 1)); dmem_ready = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            #1 e = '0; e.trap = 1'b1;
            chk_out($sformatf("trap_hold_%0d", c), get_out(), e);
        end
        do_reset("trap_clear");

        // Reset mid-MEM, then mid-FETCH
        @(negedge clk); imem_ready = 1'b1; instr = $urandom;
        @(negedge clk); imem_ready = 1'b0; instr = 32'h0000A103;
        @(negedge clk);
        @(negedge clk); dmem_ready = 1'b0;
        #1 e = '0; e.dmem_req = 1'b1; e.imm_sel = 3'd1;
        chk_out("mid_mem_before_reset", get_out(), e);
        rst_n = 1'b0;
        #1 chk_out("mid_mem_drop", get_out(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 e = '0; e.imem_req = 1'b1;
        chk_out("mid_mem_release", get_out(), e);
        rst_n = 1'b0;
        #1 chk_out("mid_fetch_drop", get_out(), '0);
        @(negedge clk);
        rst_n = 1'b1; dmem_ready = 1'b1;
        #1 chk_out("mid_fetch_release", get_out(), e);
        @(negedge clk);
        dmem_ready = 1'b0;
        #1 chk_out("after_reset_no_stray", get_out(), e);
        run_instr("post_reset_addi", 32'h00500093, 1'b0, 0, 0, 1'b0, lat, nreg, npcwe, ndreq, pcs, wbs, imd);
        chk("post_reset_addi_latency", lat, 4);

        // Randomized stream with wait states and ready noise against the phase model
        for (int n = 0; n < 200; n++) begin
            int k;
            int iw, dw, exp_lat;
            logic [2:0] im;
            logic bt;
            r   = $urandom;
            r[6:0] = ops[$urandom_range(0, 8)];
            iw  = $urandom_range(0, 3);
            dw  = $urandom_range(0, 3);
            bt  = 1'($urandom_range(0, 1));
            classify(r[6:0], k, im);
            exp_lat = (iw + 1) + 2 + (((k == K_LOAD) || (k == K_STORE)) ? dw + 1 : 0)
                    + (((k == K_BRANCH) || (k == K_STORE)) ? 0 : 1);
            run_instr($sformatf("rnd%0d_%h", n, r), r, bt, iw, dw, 1'b1,
                      lat, nreg, npcwe, ndreq, pcs, wbs, imd);
            chk($sformatf("rnd%0d_latency", n), lat, exp_lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter: Width, 32, datapath width; sizes no control port and exists only for uniformity with the datapath blocks.
REQ-002 SHALL have ports: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: instr  in  32  instruction register contents; valid from DECODE onward.
REQ-005 SHALL have ports: branch_taken  in  1  ALU compare result; sampled in EXEC only.
REQ-006 SHALL have ports: imem_req  out  1, imem_ready  in  1  instruction fetch handshake.
REQ-007 SHALL have ports: dmem_req  out  1, dmem_we  out  1, dmem_ready  in  1  data memory handshake.
REQ-008 SHALL have ports: ir_we, pc_we, reg_we  out  1 each  single-cycle write strobes.
REQ-009 SHALL have ports: pc_sel  out  2  PC source: 0 = PC+4, 1 = target, 2 = JALR (rs1+imm) with bit0 cleared.
REQ-010 SHALL have ports: imm_sel  out  3  immediate format: 0 = NONE, 1 = I, 2 = S, 3 = B, 4 = U, 5 = J.
REQ-011 SHALL have ports: alu_b_sel  out  1 (0 = rs2, 1 = imm), wb_sel  out  2 (0 = ALU, 1 = load data, 2 = PC+4).
REQ-012 SHALL have ports: trap  out  1  sticky illegal-opcode flag.

Function
REQ-013 SHALL implement the FSM states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-014 FETCH: SHALL hold imem_req=1 until imem_ready is sampled 1, then pulse ir_we for that same cycle and go to DECODE.
REQ-015 DECODE: SHALL last one cycle; classify instr[6:0] into LOAD, STORE, BRANCH, OPIMM, OP, LUI, AUIPC, JAL, JALR; any other opcode goes to TRAP.
REQ-016 imm_sel SHALL be driven from instr[6:0] in DECODE, EXEC, MEM and WB, and SHALL be NONE in FETCH and TRAP.
REQ-017 EXEC: SHALL last one cycle; alu_b_sel=1 for every class except OP and BRANCH.
REQ-018 EXEC transitions:
  - BRANCH SHALL assert pc_we with pc_sel = branch_taken ? 1 : 0, then go to FETCH.
  - LOAD and STORE SHALL go to MEM.
  - All other classes SHALL go to WB.
REQ-019 MEM: SHALL hold dmem_req=1 (dmem_we=1 for STORE) until dmem_ready is sampled 1.
  - STORE SHALL then assert pc_we with pc_sel=0 and go to FETCH.
  - LOAD SHALL go to WB.
REQ-020 WB: SHALL pulse reg_we and pc_we for one cycle, then go to FETCH.
  - wb_sel = 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_sel = 1 for JAL, 2 for JALR, 0 otherwise.
REQ-021 Zero-wait latency (FETCH to next FETCH) SHALL be: BRANCH 3 cycles; ALU, LUI, AUIPC, JAL, JALR and STORE 4 cycles; LOAD 5 cycles.
REQ-022 A req, once asserted, SHALL stay high until its ready is sampled; a ready seen while the corresponding req=0 SHALL be ignored.
REQ-023 TRAP SHALL be absorbing until reset: trap=1, all requests and strobes 0.
REQ-024 Every strobe and request SHALL be a Moore decode of the state and the registered class, with no combinational path from a ready input to a strobe other than the FETCH ir_we and the MEM pc_we.

Reset
REQ-025 On rst_n low, SHALL go immediately to FETCH with the class register cleared, trap=0, and every output 0, including imem_req, which SHALL be gated by rst_n.
REQ-026 A reset asserted mid-MEM or mid-FETCH SHALL drop the request asynchronously; the handshake SHALL restart with a fresh FETCH after release.
REQ-027 After rst_n deasserts, imem_req SHALL rise in the first cycle.

Structure
REQ-028 A shared package SHALL hold:
  - the state enum;
  - the imm_sel, pc_sel and wb_sel encodings;
  - the RV32I opcode constants.
  ImmGen and the datapath SHALL use the same package.
REQ-029 One sub-module, op_class_decode (combinational: opcode in; class, legal and imm_sel out), SHALL be instantiated; the FSM SHALL stay in multicycle_ctrl.

Verification
REQ-030 ADDI x1,x0,5 (0x00500093) with zero wait:
  - ir_we at cycle 1, imm_sel=1 in DECODE, alu_b_sel=1 in EXEC;
  - reg_we, pc_we and wb_sel=0 together at cycle 4;
  - imem_req high at cycle 5.
REQ-031 LW x2,0(x1) (0x0000A103) with dmem_ready delayed 3 cycles:
  - dmem_req high for exactly 4 cycles with dmem_we=0;
  - then reg_we with wb_sel=1;
  - total 8 cycles.
REQ-032 SW x1,0(x2) (0x00112023):
  - imm_sel=2, dmem_we=1;
  - pc_we with pc_sel=0 on the ready cycle;
  - reg_we never asserted.
REQ-033 BEQ (0x00000463) run twice:
  - branch_taken=1: pc_we with pc_sel=1 in cycle 3, no reg_we;
  - branch_taken=0: pc_sel=0.
REQ-034 Illegal opcode 0xFFFFFFFF:
  - trap rises the cycle after DECODE and stays high for 20 cycles with no requests;
  - reset clears it.
REQ-035 Reset pulse mid-MEM while dmem_req=1:
  - dmem_req drops within the same cycle;
  - after release, imem_req=1 in the first cycle and no stray pc_we or reg_we.
